aoi_vector_checker: RTL and testbench
=====================================

# aoi_vector_checker

Sequential stimulus generator and response checker for the 4-input AND-OR-INVERT gate block (a,b,c,d in; e,f,g out). It drives every 4-bit input vector into the gate under test and samples the gate's three outputs. It compares them against an internal golden model, counts mismatches and reports pass/fail. It sits beside the gate on the lab board or in the bench and acts as the driving and observing end of the gate's pin interface.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to run a full sweep.
- `dut_a`, `dut_b`, `dut_c`, `dut_d`  out  1 each  stimulus to the gate.
- `dut_e`, `dut_f`, `dut_g`  in  1 each  gate responses.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; level signal, held until the next accepted start or `rst`.
- `pass`  out  1  valid while `done`=1; 1 means zero mismatches.
- `err_count`  out  5  number of mismatching vectors, 0..16.
- `fail_vec`  out  4  first failing vector, as {d,c,b,a}.
- `fail_bits`  out  3  mismatch mask {e,f,g} of the first failing vector.

## Operation
- Vector register `vec[3:0]` drives the gate: a=vec[0], b=vec[1], c=vec[2], d=vec[3]. The outputs are registered.
- Golden model: e=a&b; f=c&e; g=~(f|e). `d` is driven but has no effect on the expected values.
- FSM states:
  - IDLE: waits for `start`.
  - APPLY: `vec` is stable; a settle counter runs from 0 to SETTLE-1.
  - CHECK: samples and compares `dut_e`/`dut_f`/`dut_g`.
  - DONE: results are held.
- Transitions:
  - IDLE or DONE + `start` → APPLY. On this transition `vec`=0, `err_count`=0, `fail_vec`=0, `fail_bits`=0, `done`=0 and `pass`=0.
  - APPLY → CHECK once the counter reaches SETTLE-1.
  - CHECK → APPLY with `vec`+1 when `vec`<15.
  - CHECK → DONE when `vec`=15.
- Mismatch handling:
  - A vector with any mismatching bit increments `err_count` by exactly 1.
  - `fail_vec` and `fail_bits` are captured only on the first mismatch of the sweep.
- Entering DONE: `pass` = (`err_count`==0, including the final CHECK result).
- `busy`=1 in APPLY and CHECK only.
- `start` asserted while `busy` is ignored and has no side effects.
- `vec` does not wrap: the sweep ends at 15.
- `dut_*` keep their last vector while in DONE and go to 0 in IDLE.

## Timing
- Reset values (`rst`=1 at a rising edge): state=IDLE, `vec`=0, all `dut_*`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_bits`=0.
- Reset mid-sweep aborts immediately to the reset values; no partial result is reported.
- `start` sampled at edge N gives `busy`=1 and `vec`=0 from edge N.
- Each vector occupies SETTLE+1 cycles. Gate outputs are sampled at the edge that ends the vector's CHECK cycle.
- A full sweep takes 16×(SETTLE+1) cycles. With SETTLE=2: `done`=1 and `busy`=0 exactly 48 cycles after the `start` edge.
- `err_count`, `fail_*` and `pass` update at the same edge that leaves CHECK.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `AOI_CHK_STOP_ON_FAIL_EN` defined: a CHECK that finds a mismatch goes straight to DONE, so `err_count`=1, `pass`=0, and `vec`/`dut_*` hold the failing vector.
- `AOI_CHK_STOP_ON_FAIL_EN` undefined: the full 16-vector sweep always runs and all mismatches are counted.

## Test plan
- Correct gate connected, SETTLE=2, start pulse → `done` and `pass` go 1 at cycle 48; `err_count`=0; `busy` high for cycles 0..47.
- `dut_g` forced to 0 → `err_count`=12 (vectors with a&b=0), `fail_vec`=4'h0, `fail_bits`=3'b001, `pass`=0.
- `dut_f` forced to 0 → `err_count`=2 (vectors 7 and 15), `fail_vec`=4'h7, `fail_bits`=3'b010.
- `AOI_CHK_STOP_ON_FAIL_EN` defined, `dut_e` forced to 1 → DONE after 3 cycles, `err_count`=1, `fail_vec`=0, `fail_bits`=3'b100, `dut_*` held at 0.
- `start` pulsed again at cycle 10 of a sweep → ignored, and `done` still arrives at cycle 48.
- `rst` at cycle 20 → next cycle shows all reset values; a new `start` then completes normally at +48.

Source files
------------

// File: rtl/aoi_vector_checker_if.sv
// Pin-level bundle between aoi_vector_checker and its controller/gate side.
// slave = the checker itself, master = the controller plus the gate under test.
interface aoi_vector_checker_if;
    logic       start;
    logic       dut_a;
    logic       dut_b;
    logic       dut_c;
    logic       dut_d;
    logic       dut_e;
    logic       dut_f;
    logic       dut_g;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] fail_vec;
    logic [2:0] fail_bits;

    modport slave (
        input  start, dut_e, dut_f, dut_g,
        output dut_a, dut_b, dut_c, dut_d,
        output busy, done, pass, err_count, fail_vec, fail_bits
    );

    modport master (
        output start, dut_e, dut_f, dut_g,
        input  dut_a, dut_b, dut_c, dut_d,
        input  busy, done, pass, err_count, fail_vec, fail_bits
    );
endinterface

// File: rtl/aoi_vector_checker.sv
// Exhaustive stimulus generator and response checker for the 4-input AOI gate.
// Optional macro AOI_CHK_STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module aoi_vector_checker #(
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    aoi_vector_checker_if.slave    io_bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] r_state;
    logic [3:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_errCount;
    logic [3:0] r_failVec;
    logic [2:0] r_failBits;

    logic       w_expE;
    logic       w_expF;
    logic       w_expG;
    logic [2:0] w_mismatch;
    logic       w_isMismatch;
    logic [4:0] w_errNext;
    logic       w_lastVec;
    logic       w_startOk;

    // Golden AOI response for the vector currently on the pins; d is a don't-care.
    assign w_expE       = r_vec[0] & r_vec[1];
    assign w_expF       = r_vec[2] & w_expE;
    assign w_expG       = ~(w_expF | w_expE);
    assign w_mismatch   = {io_bus.dut_e ^ w_expE, io_bus.dut_f ^ w_expF, io_bus.dut_g ^ w_expG};
    assign w_isMismatch = |w_mismatch;
    assign w_errNext    = r_errCount + {4'd0, w_isMismatch};
    assign w_lastVec    = (r_vec == 4'hF);
    assign w_startOk    = io_bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vec      <= 4'd0;
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errCount <= 5'd0;
            r_failVec  <= 4'd0;
            r_failBits <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_startOk) begin
                        r_state    <= S_APPLY;
                        r_vec      <= 4'd0;
                        r_cnt      <= 4'd0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_errCount <= 5'd0;
                        r_failVec  <= 4'd0;
                        r_failBits <= 3'd0;
                    end
                end

                S_APPLY: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_state <= S_CHECK;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_CHECK: begin
                    r_errCount <= w_errNext;
                    // Only the first failure of the sweep is kept for diagnosis.
                    if (w_isMismatch && (r_errCount == 5'd0)) begin
                        r_failVec  <= r_vec;
                        r_failBits <= w_mismatch;
                    end
`ifdef AOI_CHK_STOP_ON_FAIL_EN
                    if (w_isMismatch || w_lastVec) begin
`else
                    if (w_lastVec) begin
`endif
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_errNext == 5'd0);
                    end else begin
                        r_state <= S_APPLY;
                        r_vec   <= r_vec + 4'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.dut_a     = r_vec[0];
    assign io_bus.dut_b     = r_vec[1];
    assign io_bus.dut_c     = r_vec[2];
    assign io_bus.dut_d     = r_vec[3];
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.pass      = r_pass;
    assign io_bus.err_count = r_errCount;
    assign io_bus.fail_vec  = r_failVec;
    assign io_bus.fail_bits = r_failBits;

endmodule

// File: tb/tb_aoi_vector_checker.sv
// Self-checking bench for aoi_vector_checker: table-driven fault cases, random faults
// against a sweep-level reference model, plus restart and mid-sweep reset sequences.
module tb_aoi_vector_checker;

    localparam int SETTLE   = 2;
    localparam int VEC_CYC  = SETTLE + 1;
    localparam int MAX_WAIT = 400;

    logic clk;
    logic rst;

    aoi_vector_checker_if bus ();

    aoi_vector_checker #(.SETTLE(SETTLE)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate fault modes: 0 good, 1 g stuck 0, 2 f stuck 0, 3 e stuck 1, 4 random flip mask per vector.
    int         faultMode;
    logic [2:0] randMask [16];

    int assertCount;
    int failCount;

    int expErr;
    int expFailVec;
    int expFailBits;
    int expPass;
    int expCycles;
    int expLastVec;

    typedef struct {
        int mode;
        int err;
        int failVec;
        int failBits;
        int passBit;
    } vec_t;

    function automatic logic [2:0] goldenOf(input int v);
        bit e;
        e = ((v % 4) == 3);
        return {e, ((v % 8) == 7), !e};
    endfunction

    function automatic logic [2:0] gateOf(input int mode, input int v);
        logic [2:0] r;
        r = goldenOf(v);
        case (mode)
            1: r[0] = 1'b0;
            2: r[1] = 1'b0;
            3: r[2] = 1'b1;
            4: r = r ^ randMask[v];
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [2:0] o;
        o = gateOf(faultMode, int'({bus.dut_d, bus.dut_c, bus.dut_b, bus.dut_a}));
        bus.dut_e = o[2];
        bus.dut_f = o[1];
        bus.dut_g = o[0];
    end

    task automatic computeExpected(input int mode);
        logic [2:0] m;
        expErr = 0; expFailVec = 0; expFailBits = 0;
        expCycles = 16 * VEC_CYC; expLastVec = 15;
        for (int v = 0; v < 16; v++) begin
            m = gateOf(mode, v) ^ goldenOf(v);
            if (m != 3'b000) begin
                if (expErr == 0) begin
                    expFailVec  = v;
                    expFailBits = int'(m);
                end
                expErr++;
`ifdef AOI_CHK_STOP_ON_FAIL_EN
                expCycles  = (v + 1) * VEC_CYC;
                expLastVec = v;
                break;
`endif
            end
        end
        expPass = (expErr == 0) ? 1 : 0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_done"}, int'(bus.done), 0);
        checkOutput({tag, "_pass"}, int'(bus.pass), 0);
        checkOutput({tag, "_err"}, int'(bus.err_count), 0);
        checkOutput({tag, "_failvec"}, int'(bus.fail_vec), 0);
        checkOutput({tag, "_failbits"}, int'(bus.fail_bits), 0);
        checkOutput({tag, "_pins"}, int'({bus.dut_d, bus.dut_c, bus.dut_b, bus.dut_a}), 0);
    endtask

    // Pulses start, then counts edges until done; optionally re-pulses start or resets mid-sweep.
    task automatic applyStimulus(input int restartAt, input int resetAt,
                                 output int cycles, output bit busyOk, output bit aborted);
        cycles = 0; busyOk = 1'b1; aborted = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("start_busy", int'(bus.busy), 1);
        checkOutput("start_pins", int'({bus.dut_d, bus.dut_c, bus.dut_b, bus.dut_a}), 0);
        while (cycles < MAX_WAIT) begin
            if (cycles == restartAt) bus.start = 1'b1;
            if (cycles == resetAt) rst = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
            bus.start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (bus.done) break;
            if (!bus.busy) busyOk = 1'b0;
        end
    endtask

    task automatic runCase(input string tag, input int mode, input int restartAt);
        int cycles;
        bit busyOk;
        bit aborted;
        faultMode = mode;
        computeExpected(mode);
        applyStimulus(restartAt, -1, cycles, busyOk, aborted);
        checkOutput({tag, "_cycles"}, cycles, expCycles);
        checkOutput({tag, "_busy_during"}, int'(busyOk), 1);
        checkOutput({tag, "_busy_after"}, int'(bus.busy), 0);
        checkOutput({tag, "_err"}, int'(bus.err_count), expErr);
        checkOutput({tag, "_failvec"}, int'(bus.fail_vec), expFailVec);
        checkOutput({tag, "_failbits"}, int'(bus.fail_bits), expFailBits);
        checkOutput({tag, "_pass"}, int'(bus.pass), expPass);
        checkOutput({tag, "_held_pins"}, int'({bus.dut_d, bus.dut_c, bus.dut_b, bus.dut_a}), expLastVec);
    endtask

    vec_t table_q [4];

    initial begin
        int cycles;
        bit busyOk;
        bit aborted;

        assertCount = 0;
        failCount   = 0;
        faultMode   = 0;
        bus.start   = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < 16; i++) randMask[i] = 3'b000;

`ifdef AOI_CHK_STOP_ON_FAIL_EN
        table_q[0] = '{mode: 0, err: 0,  failVec: 0, failBits: 0, passBit: 1};
        table_q[1] = '{mode: 1, err: 1,  failVec: 0, failBits: 1, passBit: 0};
        table_q[2] = '{mode: 2, err: 1,  failVec: 7, failBits: 2, passBit: 0};
        table_q[3] = '{mode: 3, err: 1,  failVec: 0, failBits: 4, passBit: 0};
`else
        table_q[0] = '{mode: 0, err: 0,  failVec: 0, failBits: 0, passBit: 1};
        table_q[1] = '{mode: 1, err: 12, failVec: 0, failBits: 1, passBit: 0};
        table_q[2] = '{mode: 2, err: 2,  failVec: 7, failBits: 2, passBit: 0};
        table_q[3] = '{mode: 3, err: 12, failVec: 0, failBits: 4, passBit: 0};
`endif

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        foreach (table_q[i]) begin
            runCase($sformatf("table%0d", i), table_q[i].mode, -1);
            checkOutput($sformatf("table%0d_err_const", i), int'(bus.err_count), table_q[i].err);
            checkOutput($sformatf("table%0d_failvec_const", i), int'(bus.fail_vec), table_q[i].failVec);
            checkOutput($sformatf("table%0d_failbits_const", i), int'(bus.fail_bits), table_q[i].failBits);
            checkOutput($sformatf("table%0d_pass_const", i), int'(bus.pass), table_q[i].passBit);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++)
                randMask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            runCase($sformatf("rand%0d", r), 4, -1);
        end

        // A start during a sweep must neither restart nor disturb it.
        runCase("restart", 0, 10);
        runCase("restart_fault", 2, 10);

        faultMode = 1;
        applyStimulus(-1, 20, cycles, busyOk, aborted);
        checkOutput("midreset_aborted", int'(aborted), 1);
        checkResetValues("midreset");
        runCase("after_reset", 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
